pattern_gen: RTL and testbench
==============================

// Module: pattern_gen
// PURPOSE
//  Serial frame transmitter; opposite end of the pattern_det serial link.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Emits a fixed SYNC_PAT preamble, then the word MSB-first, one bit per clk.
//  - Follows each frame with GAP_CYC idle-zero cycles.
//  - Drives the single-bit 'in' of pattern_det-style detectors; SYNC_PAT is the sequence they look for.
// PARAMETERS
//  DATA_W    24       payload width in bits (>=1)
//  SYNC_W    4        preamble length in bits (>=1)
//  SYNC_PAT  4'b1001  preamble value, sent MSB first, width SYNC_W
//  GAP_CYC   2        idle cycles after the last payload bit (0 allowed)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  in_data    in   DATA_W  payload word
//  in_valid   in   1       in_data is valid
//  in_ready   out  1       block can accept a word (high only in IDLE)
//  out        out  1       serial bit stream to the detector
//  out_valid  out  1       'out' carries a preamble or payload bit
//  sync_flag  out  1       'out' carries a preamble bit
//  busy       out  1       any state other than IDLE
//  done       out  1       1-cycle pulse coincident with the last payload bit
// BEHAVIOUR
//  Reset:
//   - rst sampled high -> next edge: state=IDLE.
//   - After that edge: out=0, out_valid=0, sync_flag=0, busy=0, done=0, in_ready=1.
//   - Shift register and counters are cleared.
//  Outputs: all are registers; there is no combinational path from inputs to outputs.
//  FSM:
//   - IDLE: in_ready=1, out=0.
//     - in_valid&&in_ready at edge k -> latch in_data; state=SYNC after edge k.
//   - SYNC: SYNC_W cycles; out=SYNC_PAT[SYNC_W-1-i], out_valid=1, sync_flag=1.
//     - Moves to DATA after the last preamble bit.
//   - DATA: DATA_W cycles; out=word[DATA_W-1-i], out_valid=1, sync_flag=0.
//     - done=1 during bit DATA_W-1.
//     - Moves to GAP, or to IDLE when GAP_CYC=0.
//   - GAP: GAP_CYC cycles; out=0, out_valid=0, busy=1 -> IDLE.
//  Timing:
//   - Latency: first preamble bit is visible in the cycle after the accepting edge.
//   - Frame period: 1 + SYNC_W + DATA_W + GAP_CYC cycles with continuous in_valid.
//     This is 31 at the default parameters.
//  Handshake / input changes:
//   - in_data is sampled only at the accepting edge; later changes to in_data have no effect.
//   - in_valid while busy is ignored (in_ready=0).
//   - The source must hold in_data/in_valid until it sees in_ready.
//  Reset mid-frame: the frame is aborted; no done pulse; the next edge returns to the reset values.
//   rst has priority over a simultaneous handshake.
//  Counters: bit counter width is clog2(max(SYNC_W,DATA_W,GAP_CYC)+1); it never wraps inside a state.
// STRUCTURE
//  pattern_pkg:
//   - state enum IDLE/SYNC/DATA/GAP (2 bits).
//   - Default SYNC_PAT/SYNC_W constants.
//   - clog2 function.
//  Sub-module piso_shift #(W):
//   - Parallel load, shift left, MSB output.
//   - Instantiated once for the payload; the preamble comes from a constant index.
//  The FSM and counters live in pattern_gen.
// TESTING
//  Reset values (all defaults):
//   - Hold rst 3 cycles with in_valid=1 -> out=0, out_valid=0, done=0, in_ready=1.
//   - No frame starts until rst falls.
//  Single frame (defaults, in_data=24'hC90940, one-cycle valid):
//   - out = 1001 then 1100_1001_0000_1001_0100_0000.
//   - sync_flag high for 4 bits; done on bit 24; then 2 zero cycles; then in_ready=1.
//  Back-to-back (in_valid held high, words 24'hFFFFFF then 24'h000001):
//   - Second preamble starts exactly 31 cycles after the first.
//   - in_ready high only 1 cycle per frame.
//  Reset mid-frame: assert rst at payload bit 10 -> next edge returns to reset values, no done pulse.
//   A new word after that gives a complete frame.
//  GAP_CYC=0, DATA_W=8, word 8'hA5:
//   - out = 1001_10100101; done on the final bit.
//   - in_ready=1 in the next cycle; period 13.
//  Loopback with pattern_det: random words -> detector hits align with every preamble.
//   Payload-induced 1001 hits are checked against the reference model.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants and helpers for the serial frame transmitter.
package pattern_pkg;

    // FSM state encoding (2 bits)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SYNC = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    // Default preamble: the sequence pattern_det-style detectors look for
    localparam int                    DEF_SYNC_W   = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b1001;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in, serial-out shifter: load a word, shift left, MSB is the serial bit.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    // Load has priority over shift; zeros fill from the LSB end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/pattern_gen.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle-zero gap.
// All outputs are registers computed from the next-state values, so each
// output reflects the state the FSM is in during that same cycle.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int                DATA_W   = 24,
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
    parameter int                GAP_CYC  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_o,
    output logic              out_valid_o,
    output logic              sync_flag_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_CYC);
    localparam int CW      = clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    // GAP is unreachable when GAP_CYC = 0; the value then only has to be legal
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          shift_en;
    logic          shift_msb;
    logic          sync_bit;

    logic in_ready_q, out_q, out_valid_q, sync_flag_q, busy_q, done_q;

    // Next-state and bit counter; the counter restarts at 0 on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Preamble bit for the upcoming cycle, selected by constant index
    always_comb begin
        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (cnt_d == CW'(SYNC_W - 1 - i)) sync_bit = SYNC_PAT[i];
        end
    end

    // The shifter's current MSB is registered into out_q as the shifter advances
    assign shift_en = (state_d == ST_DATA);

    piso_shift #(.W(DATA_W)) u_piso (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (accept),
        .shift_i (shift_en),
        .data_i  (in_data_i),
        .msb_o   (shift_msb)
    );

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_ready_q  <= 1'b1;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sync_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_q       <= (state_d == ST_SYNC) ? sync_bit :
                           (state_d == ST_DATA) ? shift_msb : 1'b0;
            out_valid_q <= (state_d == ST_SYNC) || (state_d == ST_DATA);
            sync_flag_q <= (state_d == ST_SYNC);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DATA) && (cnt_d == DATA_LAST);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign sync_flag_o = sync_flag_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: default instance plus an 8-bit, no-gap instance.
module tb_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst, vld, rdy, o, ov, sf, bz, dn;
    logic [23:0] data;
    // DATA_W=8, GAP_CYC=0 instance
    logic        rst2, vld2, rdy2, o2, ov2, sf2, bz2, dn2;
    logic [7:0]  data2;

    pattern_gen dut (
        .clk_i(clk), .rst_i(rst), .in_data_i(data), .in_valid_i(vld),
        .in_ready_o(rdy), .out_o(o), .out_valid_o(ov), .sync_flag_o(sf),
        .busy_o(bz), .done_o(dn)
    );

    pattern_gen #(.DATA_W(8), .GAP_CYC(0)) dut2 (
        .clk_i(clk), .rst_i(rst2), .in_data_i(data2), .in_valid_i(vld2),
        .in_ready_o(rdy2), .out_o(o2), .out_valid_o(ov2), .sync_flag_o(sf2),
        .busy_o(bz2), .done_o(dn2)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One row: inputs for the next edge, expected {out,out_valid,sync,done,busy,ready} after it
    typedef struct {
        logic        rst;
        logic        vld;
        logic [23:0] data;
        logic [5:0]  exp;
    } vec_t;

    vec_t        tbl[34];
    logic [27:0] stream_v;

    initial begin
        rst = 1'b1; vld = 1'b0; data = '0;
        rst2 = 1'b1; vld2 = 1'b0; data2 = '0;

        // ---------------- reset + single frame, table driven ----------------
        stream_v = 28'b1001_1100_1001_0000_1001_0100_0000;
        for (int i = 0; i < 34; i++) begin
            tbl[i].rst  = (i < 3);
            tbl[i].vld  = (i <= 3);
            tbl[i].data = (i <= 3) ? 24'hC90940 : 24'h0;
            if (i < 3)       tbl[i].exp = 6'b000001;
            else if (i < 31) tbl[i].exp = {stream_v[27-(i-3)], 1'b1, (i - 3) < 4, (i - 3) == 27, 1'b1, 1'b0};
            else if (i < 33) tbl[i].exp = 6'b000010;
            else             tbl[i].exp = 6'b000001;
        end
        for (int i = 0; i < 34; i++) begin
            rst = tbl[i].rst; vld = tbl[i].vld; data = tbl[i].data;
            tick();
            chk($sformatf("vec%0d", i), {o, ov, sf, dn, bz, rdy}, tbl[i].exp);
        end

        // ---------------- back-to-back with in_valid held ----------------
        begin
            int s1, s2, rc, nb;
            logic [55:0] cap;
            logic sfp;
            s1 = -1; s2 = -1; rc = 0; nb = 0; cap = '0; sfp = 1'b0;
            vld = 1'b1; data = 24'hFFFFFF;
            for (int c = 0; c < 150 && nb < 56; c++) begin
                tick();
                if (bz) data = 24'h000001;
                if (sf && !sfp) begin
                    if (s1 < 0) s1 = c;
                    else if (s2 < 0) s2 = c;
                end
                if (s1 >= 0 && s2 < 0 && rdy) rc++;
                if (ov) begin cap = {cap[54:0], o}; nb++; end
                sfp = sf;
            end
            vld = 1'b0;
            chk("b2b_bits", cap, {4'b1001, 24'hFFFFFF, 4'b1001, 24'h000001});
            chk("b2b_period", s2 - s1, 31);
            chk("b2b_ready_cycles", rc, 1);
            for (int n = 0; n < 100 && !rdy; n++) tick();
            chk("b2b_back_idle", {rdy, bz}, 2'b10);
        end

        // ---------------- reset mid-frame ----------------
        begin
            int dcnt, vcnt, nb;
            logic [27:0] cap;
            vld = 1'b1; data = 24'h5A5A5A;
            tick();
            vld = 1'b0;
            for (int k = 0; k < 14; k++) tick();
            chk("mid_at_bit10", {o, ov, sf, bz}, 4'b0101);
            rst = 1'b1; vld = 1'b1;
            tick();
            chk("mid_reset_vals", {o, ov, sf, dn, bz, rdy}, 6'b000001);
            rst = 1'b0; vld = 1'b0;
            dcnt = 0; vcnt = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (dn) dcnt++;
                if (ov) vcnt++;
            end
            chk("mid_no_done", dcnt, 0);
            chk("mid_no_output", vcnt, 0);
            // fresh frame after the abort
            vld = 1'b1; data = 24'h3C00F1;
            tick();
            vld = 1'b0; data = 24'h0;
            nb = 0; cap = '0; dcnt = 0;
            for (int k = 0; k < 40 && nb < 28; k++) begin
                if (ov) begin
                    cap = {cap[26:0], o}; nb++;
                    if (dn) dcnt = (nb == 28) ? dcnt + 1 : dcnt + 100;
                end
                if (nb < 28) tick();
            end
            chk("mid_new_frame", cap, {4'b1001, 24'h3C00F1});
            chk("mid_new_done", dcnt, 1);
        end

        // ---------------- DATA_W=8, GAP_CYC=0 ----------------
        begin
            int t0, dcnt;
            logic [11:0] cap;
            tick(); tick();
            rst2 = 1'b0;
            chk("s_reset_ready", {rdy2, ov2, dn2}, 3'b100);
            vld2 = 1'b1; data2 = 8'hA5;
            for (int n = 0; n < 20 && !ov2; n++) tick();
            chk("s_started", ov2, 1'b1);
            t0 = cyc; cap = '0; dcnt = 0;
            for (int k = 0; k < 12; k++) begin
                cap = {cap[10:0], o2};
                if (dn2) dcnt++;
                if (k == 11) chk("s_done_last", dn2, 1'b1);
                if (k < 11) tick();
            end
            chk("s_bits", cap, 12'b1001_1010_0101);
            chk("s_done_count", dcnt, 1);
            tick();
            chk("s_ready_next", {rdy2, ov2, bz2}, 3'b100);
            tick();
            chk("s_period", {ov2, sf2, 32'(cyc - t0)}, {1'b1, 1'b1, 32'd13});
            vld2 = 1'b0;
        end

        // ---------------- loopback against a reference detector ----------------
        begin
            logic [23:0] words[6];
            logic [27:0] fb;
            logic [3:0]  dwin, mwin;
            logic        eb;
            int dh, mh, pos, f;
            for (int i = 0; i < 6; i++) words[i] = 24'($urandom);
            words[2] = 24'h999999;          // payload rich in 1001 occurrences
            for (int n = 0; n < 60 && !rdy; n++) tick();
            vld = 1'b1; data = words[0];
            for (int n = 0; n < 20 && !ov; n++) tick();
            chk("lb_started", ov, 1'b1);
            dwin = '0; mwin = '0; dh = 0; mh = 0;
            for (int c = 0; c < 186; c++) begin
                pos = c % 31; f = c / 31;
                fb = {4'b1001, words[f]};
                eb = (pos < 28) ? fb[27-pos] : 1'b0;
                chk($sformatf("lb_out_f%0d_p%0d", f, pos), o, eb);
                dwin = {dwin[2:0], o};
                mwin = {mwin[2:0], eb};
                if (dwin == 4'b1001) dh++;
                if (mwin == 4'b1001) mh++;
                if (pos == 3) chk($sformatf("lb_preamble_hit_f%0d", f), dwin, 4'b1001);
                if (pos == 0) begin
                    if (f < 5) data = words[f+1];
                    else vld = 1'b0;
                end
                tick();
            end
            chk("lb_hit_count", dh, mh);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
